// File: rtl/frame_painter_pkg.sv
// +----------------------------------------------------------------------+
// | frame_pkg                                                            |
// | Shared constants, types and helpers for the frame buffer painter.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package frame_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = 307200;
    localparam int ADDR_W   = 19;
    localparam int SPR_AW   = 12;
    localparam int COORD_W  = 11;
    localparam int SIZE_W   = 7;

    localparam logic [7:0] TRANSPARENT = 8'h00;

    typedef enum logic [1:0] {
        OP_FILL  = 2'b00,
        OP_BLIT  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_NOP   = 2'b11
    } draw_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } painter_state_t;

    typedef struct packed {
        draw_op_t                   op;
        logic signed [COORD_W-1:0]  x;
        logic signed [COORD_W-1:0]  y;
        logic [SIZE_W-1:0]          w;
        logic [SIZE_W-1:0]          h;
        logic [7:0]                 color;
        logic [SPR_AW-1:0]          spr_base;
    } draw_cmd_t;

    // Negative coordinates read as large unsigned values, so one unsigned
    // compare per axis rejects both edges of the screen.
    function automatic logic on_screen(input logic signed [COORD_W-1:0] x,
                                       input logic signed [COORD_W-1:0] y);
        return ($unsigned(x) < COORD_W'(H_RES)) && ($unsigned(y) < COORD_W'(V_RES));
    endfunction

    // Linear address y*640 + x built from shifts (640 = 512 + 128).
    function automatic logic [ADDR_W-1:0] pix_addr(input logic signed [COORD_W-1:0] x,
                                                   input logic signed [COORD_W-1:0] y);
        logic [ADDR_W-1:0] ax;
        logic [ADDR_W-1:0] ay;
        ax = ADDR_W'($unsigned(x));
        ay = ADDR_W'($unsigned(y));
        return (ay << 9) + (ay << 7) + ax;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_painter_if.sv
// +----------------------------------------------------------------------+
// | frame_painter_if                                                     |
// | Command, sprite ROM and frame buffer write signals of the painter.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface frame_painter_if;
    import frame_pkg::*;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [1:0]                 cmd_op;
    logic signed [COORD_W-1:0]  cmd_x;
    logic signed [COORD_W-1:0]  cmd_y;
    logic [SIZE_W-1:0]          cmd_w;
    logic [SIZE_W-1:0]          cmd_h;
    logic [7:0]                 cmd_color;
    logic [SPR_AW-1:0]          cmd_spr_base;
    logic [SPR_AW-1:0]          spr_addr;
    logic [7:0]                 spr_data;
    logic [ADDR_W-1:0]          frame_wrAddress;
    logic [7:0]                 frame_input;
    logic                       frame_we;
    logic                       busy;
    logic                       done;

    // Command source / environment side.
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_spr_base,
        output spr_data,
        input  cmd_ready, spr_addr, frame_wrAddress, frame_input, frame_we, busy, done
    );

    // Painter side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_spr_base,
        input  spr_data,
        output cmd_ready, spr_addr, frame_wrAddress, frame_input, frame_we, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/frame_scan_counter.sv
// +----------------------------------------------------------------------+
// | frame_scan_counter                                                   |
// | Raster (col,row) counter, col fastest, with last flag on (w-1,h-1).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_scan_counter
    import frame_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               load,
    input  wire logic               step,
    input  wire logic [SIZE_W-1:0]  w,
    input  wire logic [SIZE_W-1:0]  h,
    output logic [SIZE_W-1:0]       col,
    output logic [SIZE_W-1:0]       row,
    output logic                    last
);

    logic [SIZE_W-1:0] r_col;
    logic [SIZE_W-1:0] r_row;
    logic              w_row_end;

    // w and h are held stable by the caller for the whole scan.
    assign w_row_end = (r_col == (w - SIZE_W'(1)));
    assign last      = w_row_end && (r_row == (h - SIZE_W'(1)));
    assign col       = r_col;
    assign row       = r_row;

    // Restart at the origin on load, otherwise advance one pixel per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (load) begin
            r_col <= '0;
            r_row <= '0;
        end else if (step) begin
            if (w_row_end) begin
                r_col <= '0;
                r_row <= r_row + SIZE_W'(1);
            end else begin
                r_col <= r_col + SIZE_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_painter.sv
// +----------------------------------------------------------------------+
// | frame_painter                                                        |
// | Rasterizes fill / sprite blit / clear commands into one frame buffer |
// | write per clock, clipping at screen edges and skipping transparent.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_painter
    import frame_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    frame_painter_if.slave  bus
);

    painter_state_t             r_state;
    painter_state_t             w_next_state;
    draw_cmd_t                  r_cmd;
    draw_cmd_t                  w_new_cmd;
    logic                       w_accept;
    logic                       w_start_scan;

    logic                       r_s0_valid;
    logic [SPR_AW-1:0]          r_spr_offset;
    logic [SIZE_W-1:0]          w_col;
    logic [SIZE_W-1:0]          w_row;
    logic                       w_last;

    logic                       r_p1_valid;
    logic                       r_p1_last;
    logic [SIZE_W-1:0]          r_p1_col;
    logic [SIZE_W-1:0]          r_p1_row;
    logic                       r_out_last;

    logic [ADDR_W-1:0]          r_clr_cnt;
    logic                       w_clr_active;

    logic signed [COORD_W-1:0]  w_px;
    logic signed [COORD_W-1:0]  w_py;
    logic                       w_pix_write;

    logic                       r_we;
    logic [ADDR_W-1:0]          r_addr;
    logic [7:0]                 r_data;

    // Bundle the incoming command fields.
    always_comb begin
        w_new_cmd.op       = draw_op_t'(bus.cmd_op);
        w_new_cmd.x        = bus.cmd_x;
        w_new_cmd.y        = bus.cmd_y;
        w_new_cmd.w        = bus.cmd_w;
        w_new_cmd.h        = bus.cmd_h;
        w_new_cmd.color    = bus.cmd_color;
        w_new_cmd.spr_base = bus.cmd_spr_base;
    end

    assign w_accept     = bus.cmd_valid && (r_state == IDLE);
    assign w_start_scan = w_accept
                          && ((w_new_cmd.op == OP_FILL) || (w_new_cmd.op == OP_BLIT))
                          && (w_new_cmd.w != '0) && (w_new_cmd.h != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; degenerate commands go straight to DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_new_cmd.op == OP_CLEAR) begin
                        w_next_state = CLEAR;
                    end else if (w_start_scan) begin
                        w_next_state = SCAN;
                    end else begin
                        w_next_state = DONE;
                    end
                end
            end
            SCAN:    if (r_out_last) w_next_state = DONE;
            CLEAR:   if (r_clr_cnt == ADDR_W'(FB_DEPTH)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        bus.cmd_ready = (r_state == IDLE);
        bus.busy      = (r_state != IDLE);
        bus.done      = (r_state == DONE);
    end

    // Hold the accepted command for the whole operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= '0;
        end else if (w_accept) begin
            r_cmd <= w_new_cmd;
        end
    end

    frame_scan_counter u_scan (
        .clk  (clk),
        .rst  (rst),
        .load (w_start_scan),
        .step (r_s0_valid),
        .w    (r_cmd.w),
        .h    (r_cmd.h),
        .col  (w_col),
        .row  (w_row),
        .last (w_last)
    );

    // Stage 0: pixel valid flag and running sprite offset (wraps naturally).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0_valid   <= 1'b0;
            r_spr_offset <= '0;
        end else if (w_accept) begin
            r_s0_valid   <= w_start_scan;
            r_spr_offset <= '0;
        end else if (r_s0_valid) begin
            r_spr_offset <= r_spr_offset + SPR_AW'(1);
            if (w_last) begin
                r_s0_valid <= 1'b0;
            end
        end
    end

    assign bus.spr_addr = r_cmd.spr_base + r_spr_offset;

    // Stage 1: align the raster position with the ROM's one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_valid <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p1_col   <= '0;
            r_p1_row   <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_p1_valid <= r_s0_valid;
            r_p1_last  <= r_s0_valid && w_last;
            r_p1_col   <= w_col;
            r_p1_row   <= w_row;
            r_out_last <= r_p1_last;
        end
    end

    // Screen position wraps at 11-bit signed, so far-right origins clip.
    assign w_px = r_cmd.x + $signed({{(COORD_W-SIZE_W){1'b0}}, r_p1_col});
    assign w_py = r_cmd.y + $signed({{(COORD_W-SIZE_W){1'b0}}, r_p1_row});

    assign w_pix_write = r_p1_valid && on_screen(w_px, w_py)
                         && ((r_cmd.op == OP_FILL) || (bus.spr_data != TRANSPARENT));

    assign w_clr_active = (r_state == CLEAR) && (r_clr_cnt != ADDR_W'(FB_DEPTH));

    // Clear address counter, restarted on every accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_accept) begin
            r_clr_cnt <= '0;
        end else if (w_clr_active) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end

    // Registered write port; address and data only move when a write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_clr_active) begin
            r_we   <= 1'b1;
            r_addr <= r_clr_cnt;
            r_data <= r_cmd.color;
        end else if (w_pix_write) begin
            r_we   <= 1'b1;
            r_addr <= pix_addr(w_px, w_py);
            r_data <= (r_cmd.op == OP_FILL) ? r_cmd.color : bus.spr_data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign bus.frame_we        = r_we;
    assign bus.frame_wrAddress = r_addr;
    assign bus.frame_input     = r_data;

endmodule

`default_nettype wire
